cp0_ctrl: RTL and testbench

//  Parametrised System Control Coprocessor (CP0) for the 5-stage MIPS core; successor to the 3-register CP0.

---
 rtl/cp0_pkg.sv | 35 +++
 rtl/cp0_timer.sv | 55 +++++
 rtl/cp0_ctrl.sv | 131 +++++++++++++
 tb/tb_cp0_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the CP0 block.
//   - CP0 register numbers as seen on the MFC0/MTC0 addr bus
//   - ExcCode values delivered by the pipeline on exc_code
//   - bit positions of the Status and Cause fields the block interprets
package cp0_pkg;

    // Register numbers
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Status fields
    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_IM_LO = 8;

    // Cause fields
    localparam int CA_BD     = 31;
    localparam int CA_TI     = 30;
    localparam int CA_IP_LO  = 8;
    localparam int CA_EXC_LO = 2;

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer with a clock prescaler.
//   clk, rst      core clock, asynchronous active-low reset
//   count_we      MTC0 to Count this cycle (loads wdata, restarts prescaler)
//   compare_we    MTC0 to Compare this cycle (loads wdata, clears TI)
//   wdata         MTC0 data
//   count         current Count value
//   compare       current Compare value
//   ti            sticky timer interrupt flag
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    localparam logic [3:0] PRESC_LAST = 4'(COUNT_DIV - 1);

    logic [3:0]  presc;
    logic [31:0] count_inc;

    assign count_inc = count + 32'd1;   // wraps FFFF_FFFF -> 0

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc   <= '0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            // A Count write replaces the increment and so skips the match check.
            if (count_we) begin
                count <= wdata;
                presc <= '0;
            end else if (presc == PRESC_LAST) begin
                presc <= '0;
                count <= count_inc;
                if (count_inc == compare)
                    ti <= 1'b1;
            end else begin
                presc <= presc + 4'd1;
            end
            // Placed last so a Compare write wins over a same-cycle match.
            if (compare_we) begin
                compare <= wdata;
                ti      <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: System Control Coprocessor 0 for the 5-stage MIPS core.
//   clk, rst       core clock, asynchronous active-low reset
//   mfc0, addr     register read strobe / register number; rdata is combinational
//   mtc0, wdata    register write strobe / data
//   eret           ERET commit (clears EXL)
//   exc_valid      exception commit with exc_code, exc_pc, exc_bd, exc_badvaddr
//   hw_irq         level device interrupts, mapped to Cause.IP[2+:NUM_HW_IRQ]
//   irq_req        registered masked interrupt request
//   status_out     Status register
//   epc_out        EPC register (ERET target)
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter int          NUM_HW_IRQ   = 6,
    parameter int          COUNT_DIV    = 2,
    parameter logic [31:0] RESET_STATUS = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mfc0,
    input  logic                  mtc0,
    input  logic [4:0]            addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    input  logic                  eret,
    input  logic                  exc_valid,
    input  logic [4:0]            exc_code,
    input  logic [31:0]           exc_pc,
    input  logic                  exc_bd,
    input  logic [31:0]           exc_badvaddr,
    input  logic [NUM_HW_IRQ-1:0] hw_irq,
    output logic                  irq_req,
    output logic [31:0]           status_out,
    output logic [31:0]           epc_out
);
    logic [31:0]           status;
    logic [31:0]           epc;
    logic [31:0]           badvaddr;
    logic                  cause_bd;
    logic [4:0]            cause_exc;
    logic [1:0]            ip_sw;
    logic [NUM_HW_IRQ-1:0] hw_q;
    logic [5:0]            hw_ext;
    logic [7:0]            ip;
    logic [31:0]           cause;
    logic [31:0]           count;
    logic [31:0]           compare;
    logic                  ti;
    logic                  wr_ok;

    // MTC0 is the lowest-priority event; exception or ERET drops it.
    assign wr_ok = mtc0 && !exc_valid && !eret;

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (wr_ok && addr == REG_COUNT),
        .compare_we (wr_ok && addr == REG_COMPARE),
        .wdata      (wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    // Widen sampled lines to 6 so hw_irq[5] has a fixed slot even when absent.
    always_comb begin
        hw_ext                 = '0;
        hw_ext[NUM_HW_IRQ-1:0] = hw_q;
    end

    // IP[7] is shared between the timer and the sixth device line.
    assign ip    = {ti | hw_ext[5], hw_ext[4:0], ip_sw};
    assign cause = {cause_bd, ti, 14'b0, ip, 1'b0, cause_exc, 2'b0};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status    <= RESET_STATUS;
            epc       <= '0;
            badvaddr  <= '0;
            cause_bd  <= 1'b0;
            cause_exc <= '0;
            ip_sw     <= '0;
            hw_q      <= '0;
            irq_req   <= 1'b0;
        end else begin
            hw_q    <= hw_irq;
            irq_req <= status[ST_IE] && !status[ST_EXL] &&
                       |(ip & status[ST_IM_LO +: 8]);
            if (exc_valid) begin
                // A nested exception keeps the original return point.
                if (!status[ST_EXL]) begin
                    epc      <= exc_bd ? exc_pc - 32'd4 : exc_pc;
                    cause_bd <= exc_bd;
                end
                status[ST_EXL] <= 1'b1;
                cause_exc      <= exc_code;
                if (exc_code == EXC_ADEL || exc_code == EXC_ADES)
                    badvaddr <= exc_badvaddr;
            end else if (eret) begin
                status[ST_EXL] <= 1'b0;
            end else if (mtc0) begin
                case (addr)
                    REG_STATUS:   status   <= wdata;
                    REG_CAUSE:    ip_sw    <= wdata[CA_IP_LO +: 2];
                    REG_EPC:      epc      <= wdata;
                    REG_BADVADDR: badvaddr <= wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (mfc0) begin
            case (addr)
                REG_BADVADDR: rdata = badvaddr;
                REG_COUNT:    rdata = count;
                REG_COMPARE:  rdata = compare;
                REG_STATUS:   rdata = status;
                REG_CAUSE:    rdata = cause;
                REG_EPC:      rdata = epc;
                default:      rdata = '0;
            endcase
        end
    end

    assign status_out = status;
    assign epc_out    = epc;

endmodule

// File: tb/tb_cp0_ctrl.sv
module tb_cp0_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mfc0 = 1'b0, mtc0 = 1'b0, eret = 1'b0, exc_valid = 1'b0, exc_bd = 1'b0;
    logic [4:0]  addr = '0, exc_code = '0;
    logic [31:0] wdata = '0, exc_pc = '0, exc_badvaddr = '0;
    logic [5:0]  hw_irq = '0;
    logic [31:0] rdata, status_out, epc_out;
    logic        irq_req;
    int          checks = 0;
    int          errors = 0;

    cp0_ctrl #(.NUM_HW_IRQ(6), .COUNT_DIV(2), .RESET_STATUS(32'h0)) dut (
        .clk(clk), .rst(rst), .mfc0(mfc0), .mtc0(mtc0), .addr(addr), .wdata(wdata),
        .rdata(rdata), .eret(eret), .exc_valid(exc_valid), .exc_code(exc_code),
        .exc_pc(exc_pc), .exc_bd(exc_bd), .exc_badvaddr(exc_badvaddr), .hw_irq(hw_irq),
        .irq_req(irq_req), .status_out(status_out), .epc_out(epc_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        mtc0 = 1'b1; addr = a; wdata = d;
        tick();
        mtc0 = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        mfc0 = 1'b1; addr = a;
        #1 d = rdata;
        mfc0 = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        #3;
        checks++; if (status_out !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp 0", status_out); end
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq_req); end
        rd(5'd13, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_cause got %h exp 0", v); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_status_rw();
        logic [31:0] v;
        wr(5'd12, 32'h0000_FF01);
        rd(5'd12, v);
        checks++; if (v !== 32'h0000_FF01) begin errors++; $display("FAIL status_rd got %h exp 0000ff01", v); end
        tick(); tick();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL status_irq got %b exp 0", irq_req); end
    endtask

    task automatic test_timer();
        logic [31:0] v;
        wr(5'd12, 32'h0000_8001);          // IE, IM7
        wr(5'd9, 32'h0);
        wr(5'd11, 32'd5);                  // clears any stale TI
        wr(5'd9, 32'h0);                   // prescaler restarts here
        repeat (9) tick();
        rd(5'd9, v);
        checks++; if (v !== 32'd4) begin errors++; $display("FAIL timer_count9 got %0d exp 4", v); end
        rd(5'd13, v);
        checks++; if (v[30] !== 1'b0) begin errors++; $display("FAIL timer_ti_early got %b exp 0", v[30]); end
        tick();
        rd(5'd9, v);
        checks++; if (v !== 32'd5) begin errors++; $display("FAIL timer_count10 got %0d exp 5", v); end
        rd(5'd13, v);
        checks++; if (v[30] !== 1'b1 || v[15] !== 1'b1) begin errors++; $display("FAIL timer_ti got ti=%b ip7=%b exp 1 1", v[30], v[15]); end
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL timer_irq_early got %b exp 0", irq_req); end
        tick();
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL timer_irq got %b exp 1", irq_req); end
        wr(5'd11, 32'h0000_1000);
        rd(5'd13, v);
        checks++; if (v[30] !== 1'b0) begin errors++; $display("FAIL timer_ti_clr got %b exp 0", v[30]); end
        tick();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL timer_irq_clr got %b exp 0", irq_req); end
        wr(5'd12, 32'h0);
    endtask

    task automatic test_exception();
        logic [31:0] v;
        exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'h0040_0010; exc_bd = 1'b1; exc_badvaddr = 32'h1001;
        tick();
        exc_valid = 1'b0; exc_bd = 1'b0;
        checks++; if (epc_out !== 32'h0040_000C) begin errors++; $display("FAIL exc_epc got %h exp 0040000c", epc_out); end
        rd(5'd13, v);
        checks++; if (v[31] !== 1'b1 || v[6:2] !== 5'd4) begin errors++; $display("FAIL exc_cause got bd=%b code=%0d exp 1 4", v[31], v[6:2]); end
        rd(5'd8, v);
        checks++; if (v !== 32'h1001) begin errors++; $display("FAIL exc_badvaddr got %h exp 1001", v); end
        checks++; if (status_out[1] !== 1'b1) begin errors++; $display("FAIL exc_exl got %b exp 1", status_out[1]); end
    endtask

    task automatic test_nested();
        logic [31:0] v;
        exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h80; exc_bd = 1'b0; exc_badvaddr = 32'h2222;
        tick();
        exc_valid = 1'b0;
        checks++; if (epc_out !== 32'h0040_000C) begin errors++; $display("FAIL nest_epc got %h exp 0040000c", epc_out); end
        rd(5'd13, v);
        checks++; if (v[6:2] !== 5'd8 || v[31] !== 1'b1) begin errors++; $display("FAIL nest_cause got code=%0d bd=%b exp 8 1", v[6:2], v[31]); end
        rd(5'd8, v);
        checks++; if (v !== 32'h1001) begin errors++; $display("FAIL nest_badvaddr got %h exp 1001", v); end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        checks++; if (status_out[1] !== 1'b0 || epc_out !== 32'h0040_000C) begin errors++; $display("FAIL eret got exl=%b epc=%h exp 0 0040000c", status_out[1], epc_out); end
    endtask

    task automatic test_collisions();
        logic [31:0] v;
        mtc0 = 1'b1; addr = 5'd14; wdata = 32'hDEAD;
        exc_valid = 1'b1; exc_code = 5'd12; exc_pc = 32'h300; exc_bd = 1'b0;
        tick();
        mtc0 = 1'b0; exc_valid = 1'b0;
        checks++; if (epc_out !== 32'h300) begin errors++; $display("FAIL coll_exc got %h exp 300", epc_out); end
        mtc0 = 1'b1; addr = 5'd14; wdata = 32'hBEEF; eret = 1'b1;
        tick();
        mtc0 = 1'b0; eret = 1'b0;
        checks++; if (epc_out !== 32'h300 || status_out[1] !== 1'b0) begin errors++; $display("FAIL coll_eret got epc=%h exl=%b exp 300 0", epc_out, status_out[1]); end
        wr(5'd14, 32'h1234);
        checks++; if (epc_out !== 32'h1234) begin errors++; $display("FAIL epc_wr got %h exp 1234", epc_out); end
        wr(5'd5, 32'hFFFF_FFFF);
        rd(5'd5, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped got %h exp 0", v); end
        addr = 5'd14; mfc0 = 1'b0;
        #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rd_idle got %h exp 0", rdata); end
        wr(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, v);
        checks++; if (v !== 32'h0000_0330) begin errors++; $display("FAIL cause_wr got %h exp 00000330", v); end
        wr(5'd13, 32'h0);
    endtask

    task automatic test_hw_irq_reset();
        logic [31:0] v;
        wr(5'd12, 32'h0000_0401);          // IE, IM2
        hw_irq = 6'b000001;
        tick();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL hw_irq1 got %b exp 0", irq_req); end
        rd(5'd13, v);
        checks++; if (v[10] !== 1'b1) begin errors++; $display("FAIL hw_ip2 got %b exp 1", v[10]); end
        tick();
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL hw_irq2 got %b exp 1", irq_req); end
        hw_irq = 6'b100000;                // line 5 lands on IP7
        tick();
        rd(5'd13, v);
        checks++; if (v[15] !== 1'b1 || v[10] !== 1'b0) begin errors++; $display("FAIL hw5_ip7 got ip7=%b ip2=%b exp 1 0", v[15], v[10]); end
        hw_irq = 6'b000001;
        wr(5'd12, 32'h0000_0401);
        tick();
        #2 rst = 1'b0;
        #1;
        checks++; if (status_out !== 32'h0 || epc_out !== 32'h0 || irq_req !== 1'b0) begin errors++; $display("FAIL async_rst got st=%h epc=%h irq=%b exp 0 0 0", status_out, epc_out, irq_req); end
        rd(5'd9, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_count got %h exp 0", v); end
        hw_irq = '0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_status_rw();
        test_timer();
        test_exception();
        test_nested();
        test_collisions();
        test_hw_irq_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
